// File: rtl/int32_reduce_acc_pkg.sv
// Shared types and constants for the int32 reduction accumulator.
package int32_reduce_acc_pkg;

    localparam int INT_W        = 32;
    localparam int TREE_LAT_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on rd_data while valid.
module sync_fifo_fwft #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & valid;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/int32_reduce_acc.sv
// Accumulates add-tree beats into reduction sums and queues completed results behind a credit check.
module int32_reduce_acc
    import int32_reduce_acc_pkg::*;
#(
    parameter int TREE_LAT  = TREE_LAT_DEF,
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic signed [INT_W-1:0] tree_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [INT_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic                    busy
);

    localparam int LW  = $clog2(TREE_LAT + OUT_DEPTH + 1) + 1;
    localparam int FCW = $clog2(OUT_DEPTH + 1);
    localparam int FW  = INT_W + CNT_W;

    logic                    acc_in;
    logic [TREE_LAT-1:0]     vld_sr;
    logic [TREE_LAT-1:0]     last_sr;
    logic                    d_valid;
    logic                    d_last;
    logic [LW-1:0]           lasts_inflight;

    state_t                  state_q, state_d;
    logic signed [INT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fifo_push;
    logic signed [INT_W-1:0] push_sum;
    logic [CNT_W-1:0]        push_cnt;

    logic                    fifo_pop;
    logic                    fifo_full;
    logic [FCW-1:0]          fifo_count;
    logic [FW-1:0]           fifo_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign acc_in  = in_valid & in_ready;
    assign d_valid = vld_sr[TREE_LAT-1];
    assign d_last  = last_sr[TREE_LAT-1];

    // Issue -> tree output: flags ride alongside the tree, never stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= acc_in;
            last_sr[0] <= acc_in & in_last;
            for (int i = 1; i < TREE_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lasts_inflight <= '0;
        end else begin
            case ({acc_in & in_last, d_valid & d_last})
                2'b10:   lasts_inflight <= lasts_inflight + 1'b1;
                2'b01:   lasts_inflight <= lasts_inflight - 1'b1;
                default: lasts_inflight <= lasts_inflight;
            endcase
        end
    end

    // Every last beat already in flight has a FIFO slot reserved.
    assign in_ready = (LW'(OUT_DEPTH) - LW'(fifo_count)) > lasts_inflight;

    // Tree output -> accumulator / FIFO push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        fifo_push = 1'b0;
        push_sum  = acc_q + tree_sum;
        push_cnt  = sat_inc(cnt_q);
        case (state_q)
            IDLE: begin
                if (d_valid) begin
                    if (d_last) begin
                        fifo_push = 1'b1;
                        push_sum  = tree_sum;
                        push_cnt  = CNT_W'(1);
                    end else begin
                        acc_d   = tree_sum;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (d_valid) begin
                    if (d_last) begin
                        fifo_push = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        acc_d = acc_q + tree_sum;
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == ACCUM) | (|vld_sr);
    assign fifo_pop = out_valid & out_ready;

    // FIFO -> consumer.
    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({push_sum, push_cnt}),
        .pop       (fifo_pop),
        .rd_data   (fifo_head),
        .valid     (out_valid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_data  = fifo_head[FW-1:CNT_W];
    assign out_count = fifo_head[CNT_W-1:0];

endmodule
